pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage MIPS pipeline. It drives the enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, including the EX/MEM control register. Three events are resolved in priority order: data-memory wait, taken branch, and load-use hazard. It also tracks memory-wait timeouts and counts stall cycles for the performance counters.

---
 rtl/pipe_pkg.sv | 39 +++
 rtl/sat_counter.sv | 19 +
 rtl/pipe_hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types: hazard FSM states, register-field constants and the
// bundle of stage-register enable/flush controls.
package pipe_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        FAULT
    } hz_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic memwb_en;
        logic memwb_flush;
    } pipe_ctrl_t;

    // Uniform pattern: every enable gets en, every flush gets flush.
    function automatic pipe_ctrl_t ctrl_fill(input logic en, input logic flush);
        pipe_ctrl_t c;
        c.pc_en       = en;
        c.ifid_en     = en;
        c.ifid_flush  = flush;
        c.idex_en     = en;
        c.idex_flush  = flush;
        c.exmem_en    = en;
        c.memwb_en    = en;
        c.memwb_flush = flush;
        return c;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: memory-wait freeze, taken
// branch squash and load-use bubble, plus memory timeout fault and stall count.
//
//   state    | meaning
//   RUN      | normal flow; branch/load-use resolved combinationally
//   MEM_WAIT | data memory still busy; wait_cnt counts freeze cycles
//   FAULT    | memory timed out; pipeline halted until rst
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             memwb_flush,
    output logic             fault,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    hz_state_t  fsm;
    logic [7:0] wait_cnt;
    logic       freeze;
    logic       load_use;
    pipe_ctrl_t ctrl;

    assign freeze   = mem_req & ~mem_ready;
    assign load_use = ex_memread & (ex_rt != REG_ZERO) &
                      ((ex_rt == id_rs) | (ex_rt == id_rt));

    always_comb begin
        ctrl = ctrl_fill(1'b1, 1'b0);
        if (rst) begin
            ctrl = ctrl_fill(1'b0, 1'b1);
        end else if (fsm == FAULT) begin
            ctrl = ctrl_fill(1'b0, 1'b0);
        end else if (freeze) begin
            // MEM/WB keeps clocking but writes a bubble so the stalled
            // instruction does not write back twice.
            ctrl             = ctrl_fill(1'b0, 1'b0);
            ctrl.memwb_en    = 1'b1;
            ctrl.memwb_flush = 1'b1;
        end else if (ex_branch_taken) begin
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
        end else if (load_use) begin
            ctrl.pc_en      = 1'b0;
            ctrl.ifid_en    = 1'b0;
            ctrl.idex_flush = 1'b1;
        end
    end

    assign pc_en       = ctrl.pc_en;
    assign ifid_en     = ctrl.ifid_en;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_en     = ctrl.idex_en;
    assign idex_flush  = ctrl.idex_flush;
    assign exmem_en    = ctrl.exmem_en;
    assign memwb_en    = ctrl.memwb_en;
    assign memwb_flush = ctrl.memwb_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm      <= RUN;
            wait_cnt <= '0;
            fault    <= 1'b0;
        end else begin
            case (fsm)
                RUN: begin
                    if (freeze) begin
                        fsm      <= MEM_WAIT;
                        wait_cnt <= 8'd1;
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (freeze) begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt == WAIT_LAST) begin
                            fsm   <= FAULT;
                            fault <= 1'b1;
                        end
                    end else begin
                        fsm      <= RUN;
                        wait_cnt <= '0;
                    end
                end
                FAULT: begin
                    fault <= 1'b1;
                end
                default: begin
                    fsm      <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .clr  (rst),
        .inc  (~ctrl.pc_en & ~rst),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 4;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, memwb_flush}
    localparam logic [7:0] P_RUN    = 8'b1101_0110;
    localparam logic [7:0] P_RESET  = 8'b0010_1001;
    localparam logic [7:0] P_FREEZE = 8'b0000_0011;
    localparam logic [7:0] P_BRANCH = 8'b1111_1110;
    localparam logic [7:0] P_LOADU  = 8'b0001_1110;
    localparam logic [7:0] P_FAULT  = 8'b0000_0000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [4:0]       id_rs = '0;
    logic [4:0]       id_rt = '0;
    logic             ex_memread = 1'b0;
    logic [4:0]       ex_rt = '0;
    logic             ex_branch_taken = 1'b0;
    logic             mem_req = 1'b0;
    logic             mem_ready = 1'b0;
    logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic             exmem_en, memwb_en, memwb_flush, fault;
    logic [CNT_W-1:0] stall_cnt;
    logic [7:0]       act_ctrl;

    typedef struct {
        logic [7:0]       ctrl;
        logic             flt;
        logic [CNT_W-1:0] cnt;
        string            name;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .ex_memread     (ex_memread),
        .ex_rt          (ex_rt),
        .ex_branch_taken(ex_branch_taken),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .pc_en          (pc_en),
        .ifid_en        (ifid_en),
        .ifid_flush     (ifid_flush),
        .idex_en        (idex_en),
        .idex_flush     (idex_flush),
        .exmem_en       (exmem_en),
        .memwb_en       (memwb_en),
        .memwb_flush    (memwb_flush),
        .fault          (fault),
        .stall_cnt      (stall_cnt)
    );

    assign act_ctrl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                       exmem_en, memwb_en, memwb_flush};

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                checks++;
                if (act_ctrl !== cur.ctrl) begin
                    errors++;
                    $display("FAIL %s ctrl: got %b want %b", cur.name, act_ctrl, cur.ctrl);
                end
                checks++;
                if (fault !== cur.flt) begin
                    errors++;
                    $display("FAIL %s fault: got %b want %b", cur.name, fault, cur.flt);
                end
                checks++;
                if (stall_cnt !== cur.cnt) begin
                    errors++;
                    $display("FAIL %s stall_cnt: got %0d want %0d", cur.name, stall_cnt, cur.cnt);
                end
            end
        end
    end

    task automatic step(input logic r, input logic req, input logic rdy, input logic br,
                        input logic mrd, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] ert, input logic [7:0] ec, input logic ef,
                        input int es, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst             = r;
        mem_req         = req;
        mem_ready       = rdy;
        ex_branch_taken = br;
        ex_memread      = mrd;
        id_rs           = rs;
        id_rt           = rt;
        ex_rt           = ert;
        e.ctrl = ec;
        e.flt  = ef;
        e.cnt  = es[CNT_W-1:0];
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [7:0] ec, input logic ef, input int es, input string nm);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, ec, ef, es, nm);
    endtask

    initial begin
        // reset
        step(1, 0, 0, 0, 0, 0, 0, 0, P_RESET, 0, 0, "reset0");
        step(1, 0, 0, 0, 0, 0, 0, 0, P_RESET, 0, 0, "reset1");
        idle(P_RUN, 0, 0, "run_idle");
        // load-use on rs, single bubble
        step(0, 0, 0, 0, 1, 5'd8, 5'd2, 5'd8, P_LOADU, 0, 0, "loaduse_rs");
        idle(P_RUN, 0, 1, "after_loaduse");
        // $zero never hazards
        step(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, P_RUN, 0, 1, "zero_reg");
        // load-use on rt, then a non-matching load
        step(0, 0, 0, 0, 1, 5'd3, 5'd5, 5'd5, P_LOADU, 0, 1, "loaduse_rt");
        step(0, 0, 0, 0, 1, 5'd6, 5'd7, 5'd5, P_RUN, 0, 2, "load_nomatch");
        // branch beats load-use
        step(0, 0, 0, 1, 1, 5'd9, 5'd1, 5'd9, P_BRANCH, 0, 2, "branch_over_lu");
        idle(P_RUN, 0, 2, "after_branch");
        // 3-cycle memory wait with a branch held, applied on release
        step(0, 1, 0, 1, 0, 0, 0, 0, P_FREEZE, 0, 2, "memwait1");
        step(0, 1, 0, 1, 0, 0, 0, 0, P_FREEZE, 0, 3, "memwait2");
        step(0, 1, 0, 1, 0, 0, 0, 0, P_FREEZE, 0, 4, "memwait3");
        step(0, 1, 1, 1, 0, 0, 0, 0, P_BRANCH, 0, 5, "memwait_release");
        idle(P_RUN, 0, 5, "after_memwait");
        // ready same cycle as req: no freeze
        step(0, 1, 1, 0, 0, 0, 0, 0, P_RUN, 0, 5, "mem_zero_lat");
        // timeout after 4 freeze cycles
        step(0, 1, 0, 0, 0, 0, 0, 0, P_FREEZE, 0, 5, "tmo1");
        step(0, 1, 0, 0, 0, 0, 0, 0, P_FREEZE, 0, 6, "tmo2");
        step(0, 1, 0, 0, 0, 0, 0, 0, P_FREEZE, 0, 7, "tmo3");
        step(0, 1, 0, 0, 0, 0, 0, 0, P_FREEZE, 0, 8, "tmo4");
        step(0, 1, 0, 0, 0, 0, 0, 0, P_FAULT, 1, 9, "fault_entered");
        step(0, 1, 1, 0, 0, 0, 0, 0, P_FAULT, 1, 10, "fault_ignore_ready");
        idle(P_FAULT, 1, 11, "fault_sticky");
        step(1, 0, 0, 0, 0, 0, 0, 0, P_RESET, 1, 12, "fault_rst_a");
        step(1, 0, 0, 0, 0, 0, 0, 0, P_RESET, 0, 0, "fault_rst_b");
        idle(P_RUN, 0, 0, "after_fault_rst");
        // reset mid-wait with wait_cnt=2
        step(0, 1, 0, 0, 0, 0, 0, 0, P_FREEZE, 0, 0, "mw_a");
        step(0, 1, 0, 0, 0, 0, 0, 0, P_FREEZE, 0, 1, "mw_b");
        step(1, 1, 0, 0, 0, 0, 0, 0, P_RESET, 0, 2, "mw_rst");
        idle(P_RUN, 0, 0, "mw_after_rst");
        step(0, 1, 0, 0, 0, 0, 0, 0, P_FREEZE, 0, 0, "mw2_1");
        step(0, 1, 0, 0, 0, 0, 0, 0, P_FREEZE, 0, 1, "mw2_2");
        step(0, 1, 0, 0, 0, 0, 0, 0, P_FREEZE, 0, 2, "mw2_3");
        step(0, 1, 1, 0, 0, 0, 0, 0, P_RUN, 0, 3, "mw2_release");
        idle(P_RUN, 0, 3, "mw2_idle");
        // counter keeps running in FAULT and saturates at 15
        for (int k = 0; k < 20; k++) begin
            step(0, 1, 0, 0, 0, 0, 0, 0,
                 (k < 4) ? P_FREEZE : P_FAULT, (k >= 4) ? 1'b1 : 1'b0,
                 (3 + k > 15) ? 15 : 3 + k, "sat");
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
